action_judge: RTL
=================

ACTION_JUDGE -- requirements
Module: action_judge

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning raw hand inputs must hold stable this many cycles before acceptance.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 2500000, meaning the player pose must match the boss pose continuously this many cycles to score.
REQ-003 The block SHALL have parameter WINDOW_CYCLES, default 50000000, meaning the number of cycles allowed per round before a miss.
REQ-004 The block SHALL have parameter COOLDOWN_CYCLES, default 5000000, meaning the dead time after each hit or miss.
REQ-005 The block SHALL have parameter MAX_MISS, default 9, range 1-15, meaning the miss count that ends the game.
REQ-006 The block SHALL have port clk, input, 1, the single system clock.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port left_hand, input, 1, raw asynchronous switch, 1 = left hand raised.
REQ-009 The block SHALL have port right_hand, input, 1, raw asynchronous switch, 1 = right hand raised.
REQ-010 The block SHALL have port boss_state, input, 2, current boss pose (11 UP, 00 DOWN, 10 LEFTUP, 01 RIGHTUP).
REQ-011 The block SHALL have port right, output, 1, one-cycle pulse on a scored match; feeds the boss stage.
REQ-012 The block SHALL have port miss, output, 1, one-cycle pulse on window expiry.
REQ-013 The block SHALL have port player_state, output, 2, debounced pose {left, right} in the boss_state encoding.
REQ-014 The block SHALL have port miss_count, output, 4, saturating miss total.
REQ-015 The block SHALL have port game_over, output, 1, high once miss_count reaches MAX_MISS.

Function
REQ-016 Each hand input SHALL pass a 2-flop synchronizer; a debounce counter per hand SHALL update the accepted value only after DEBOUNCE_CYCLES consecutive identical synchronized samples, and any differing sample SHALL clear that counter.
REQ-017 player_state SHALL equal {debounced left, debounced right}; latency from a clean input edge to player_state change is 2 + DEBOUNCE_CYCLES cycles.
REQ-018 The FSM SHALL have states COOLDOWN, WATCH, HIT, MISS, OVER.
REQ-019 COOLDOWN SHALL count COOLDOWN_CYCLES, then enter WATCH with the window and hold counters cleared.
REQ-020 In WATCH the window counter SHALL increment every cycle; the hold counter SHALL increment while player_state == boss_state and clear to 0 on any cycle they differ, including a boss_state change.
REQ-021 The hold counter reaching HOLD_CYCLES SHALL move WATCH to HIT; the window counter reaching WINDOW_CYCLES SHALL move WATCH to MISS; if both occur the same cycle, HIT SHALL win.
REQ-022 HIT SHALL assert right for exactly one cycle, then go to COOLDOWN; right SHALL be low in every other state.
REQ-023 MISS SHALL assert miss for exactly one cycle, increment miss_count (saturating at 15), then go to OVER if the new count >= MAX_MISS, else to COOLDOWN.
REQ-024 OVER SHALL hold game_over high and right and miss low, and SHALL exit only by reset; hand inputs SHALL still update player_state.
REQ-025 Counters SHALL be sized to hold their parameter value without wrap; no counter SHALL wrap to 0 except by the explicit clears above.

Reset
REQ-026 Asserting reset low SHALL immediately force the FSM to COOLDOWN with its counter cleared, right=0, miss=0, player_state=00, miss_count=0, game_over=0, all synchronizer, debounce, window and hold registers to 0.
REQ-027 Reset asserted mid-round, including during HIT or MISS, SHALL discard the pending pulse; no right or miss pulse SHALL be emitted for that round.
REQ-028 After reset deasserts, the first WATCH SHALL begin after COOLDOWN_CYCLES cycles.

Verification (DEBOUNCE=4, HOLD=8, WINDOW=100, COOLDOWN=10, MAX_MISS=3)
REQ-029 Bench: boss_state=01, set right_hand=1 left_hand=0 cleanly during COOLDOWN -> player_state=01 after 6 cycles, one right pulse exactly 8 cycles into WATCH, miss stays 0.
REQ-030 Bench: right_hand toggles every 2 cycles for 40 cycles -> player_state never changes, no right pulse.
REQ-031 Bench: pose matches 5 cycles, breaks 1 cycle, matches again -> right pulse only after 8 further consecutive matching cycles.
REQ-032 Bench: no match for three full windows -> miss pulses at WATCH cycle 100 of each round, miss_count 1,2,3, game_over=1 after the third, no further pulses.
REQ-033 Bench: align so hold reaches 8 on window cycle 100 -> right pulses, miss does not, miss_count unchanged.
REQ-034 Bench: assert reset during HIT -> right stays 0, all outputs at reset values, next WATCH 10 cycles after release.

Source files
------------

// File: rtl/action_judge.sv
// action_judge: debounces the two hand switches into a player pose, compares
// it with the boss pose each round, and reports hits, misses and game over.
module action_judge #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 2500000,
  parameter int WINDOW_CYCLES   = 50000000,
  parameter int COOLDOWN_CYCLES = 5000000,
  parameter int MAX_MISS        = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_hand,
  input  logic       right_hand,
  input  logic [1:0] boss_state,
  output logic       right,
  output logic       miss,
  output logic [1:0] player_state,
  output logic [3:0] miss_count,
  output logic       game_over
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
  localparam int CD_W   = $clog2(COOLDOWN_CYCLES + 1);

  // A differing sample is accepted on its DEBOUNCE_CYCLES-th consecutive cycle.
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [WIN_W-1:0]  WIN_LIMIT  = WIN_W'(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]  WIN_ONE    = WIN_W'(1);
  localparam logic [CD_W-1:0]   CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CD_W-1:0]   CD_ONE     = CD_W'(1);
  localparam logic [3:0]        MISS_LIMIT = 4'(MAX_MISS);

  typedef enum logic [2:0] {
    S_COOLDOWN,
    S_WATCH,
    S_HIT,
    S_MISS,
    S_OVER
  } state_t;

  // Bit 1 carries the left hand, bit 0 the right hand, matching boss_state.
  logic [1:0]            hand_raw;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  state_t                state_q, state_d;
  logic [CD_W-1:0]       cd_cnt_q, cd_cnt_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [3:0]            miss_cnt_q, miss_cnt_d;

  assign hand_raw = {left_hand, right_hand};

  // Synchronize both hands, then accept a new level only after it has held long enough.
  always_comb begin
    sync1_d  = hand_raw;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int h = 0; h < 2; h++) begin
      if (sync2_q[h] != deb_q[h]) begin
        if (db_cnt_q[h] == DB_LAST) begin
          deb_d[h] = sync2_q[h];
        end else begin
          db_cnt_d[h] = db_cnt_q[h] + DB_ONE;
        end
      end
    end
  end

  // Round sequencing: cooldown, watch for a held match, then score a hit or a miss.
  always_comb begin
    state_d    = state_q;
    cd_cnt_d   = cd_cnt_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_COOLDOWN: begin
        if (cd_cnt_q == CD_LAST) begin
          state_d    = S_WATCH;
          cd_cnt_d   = '0;
          win_cnt_d  = '0;
          hold_cnt_d = '0;
        end else begin
          cd_cnt_d = cd_cnt_q + CD_ONE;
        end
      end
      S_WATCH: begin
        win_cnt_d  = win_cnt_q + WIN_ONE;
        hold_cnt_d = (deb_q == boss_state) ? hold_cnt_q + HOLD_ONE : '0;
        if (hold_cnt_d == HOLD_LIMIT) begin
          state_d = S_HIT;
        end else if (win_cnt_d == WIN_LIMIT) begin
          state_d = S_MISS;
        end
      end
      S_HIT: begin
        state_d  = S_COOLDOWN;
        cd_cnt_d = '0;
      end
      S_MISS: begin
        miss_cnt_d = (miss_cnt_q == 4'hF) ? 4'hF : miss_cnt_q + 4'd1;
        cd_cnt_d   = '0;
        state_d    = (miss_cnt_d >= MISS_LIMIT) ? S_OVER : S_COOLDOWN;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d  = S_COOLDOWN;
        cd_cnt_d = '0;
      end
    endcase
  end

  // All state registers; reset clears everything and restarts in cooldown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      db_cnt_q   <= '0;
      state_q    <= S_COOLDOWN;
      cd_cnt_q   <= '0;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      cd_cnt_q   <= cd_cnt_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign right        = (state_q == S_HIT);
  assign miss         = (state_q == S_MISS);
  assign game_over    = (state_q == S_OVER);
  assign player_state = deb_q;
  assign miss_count   = miss_cnt_q;

endmodule
